arbitro_rr: RTL
===============

// Module: arbitro_rr
// PURPOSE
//  Parametrised successor arbiter between NUM_CH input ("naranja") FIFOs and the output ("morado") FIFO bank.
//  Each cycle it pops at most one non-empty input FIFO, chosen by fixed or round-robin priority.
//  Pops are gated by downstream almost_full. It issues a registered push, plus the source channel index, one cycle later.
//  This aligns the push with the 1-cycle FIFO read latency.
//  Sits between the input FIFO bank and the output FIFO demux; the FSM consumes the empties vector.
// PARAMETERS
//  NUM_CH     4        number of channels (2..16)
//  CH_W       2        $clog2(NUM_CH); width of channel index
//  STATE_W    4        width of FSM state input
//  INIT_STATE 4'b0001  FSM state in which arbitration is frozen
//  RR_MODE    1        0 = fixed priority (ch0 highest), 1 = round-robin
// PORTS
//  clk          in   1           clock, all flops rising edge
//  reset        in   1           asynchronous, active-high reset
//  state        in   STATE_W     current FSM state
//  empty_in     in   NUM_CH      empty flags of input FIFOs
//  empty_out    in   NUM_CH      empty flags of output FIFOs
//  almost_full  in   NUM_CH      almost_full flags of output FIFOs
//  pop          out  NUM_CH      one-hot (or zero) pop to input FIFOs, combinational
//  push         out  1           registered: data from last cycle's pop is valid, write output FIFO
//  push_sel     out  CH_W        registered: channel index popped last cycle (demux select)
//  empties      out  2*NUM_CH    registered {empty_out, empty_in} status for FSM
//  grant_cnt_ov out  1           sticky flag: a per-channel grant counter wrapped
// BEHAVIOUR
//  Reset (async, immediate): push=0, push_sel=0, empties=0, rr_ptr=0, grant counters=0, grant_cnt_ov=0.
//   pop=0 while reset is high.
//  stall = |almost_full. frozen = (state==INIT_STATE).
//  pop (comb): all zero if reset|frozen|stall or all empty_in=1.
//   Otherwise one-hot on the winning channel.
//  Fixed mode: winner = lowest index i with empty_in[i]==0.
//  RR mode: winner = first i with empty_in[i]==0, searching rr_ptr, rr_ptr+1, ... NUM_CH-1, 0, ... (wraps).
//  rr_ptr update (on a grant only): rr_ptr <= (win==NUM_CH-1) ? 0 : win+1; otherwise it holds.
//   In fixed mode rr_ptr stays 0.
//  Pipeline: push <= |pop; push_sel <= win when |pop, else it holds its old value. Latency pop->push = 1 cycle exactly.
//  almost_full rising in the same cycle as a candidate pop blocks that pop. A push already in flight still completes.
//   almost_full margin must cover this one extra write.
//  frozen: pop=0 and empties <= 0. The next-cycle push still retires any pop made before entering INIT_STATE.
//  Otherwise empties <= {empty_out, empty_in} every cycle (1-cycle lag).
//  Grant counters: 8-bit per channel, increment on a grant, wrap 255->0.
//   A wrap sets grant_cnt_ov, which is cleared only by reset.
//  Reset mid-operation drops any in-flight push (push forced 0); the upstream word is lost by design.
//  Never pop an empty FIFO; never pop more than one FIFO per cycle.
// STRUCTURE
//  Package arbitro_pkg: INIT_STATE, mode localparams (MODE_FIXED=0, MODE_RR=1), default NUM_CH/CH_W.
//  Sub-module prio_pick #(N): request vector + start pointer -> one-hot grant + index + valid.
//   It rotates the request vector, finds the lowest set bit, then un-rotates.
//   It is instantiated once; fixed mode ties start to 0.
//  Top level: gating logic, rr_ptr register, push/push_sel pipeline, empties register, grant counters.
// TESTING
//  1 Reset then state=INIT_STATE, empty_in=4'b0000 -> pop=0, push=0, empties=0 for the whole window.
//  2 RR, state=0, empty_in=4'b0000 held 8 cycles -> pop sequence 0001,0010,0100,1000,0001,...
//    push=1 from cycle 2, with push_sel=0,1,2,3,0 lagging pop by one cycle.
//  3 RR, empty_in=4'b1010 (ch0,ch2 non-empty) -> pop alternates 0001/0100; ptr wraps 3->0 correctly.
//  4 Fixed mode, empty_in=4'b0110 -> pop=0001 continuously; then empty_in=4'b0111 -> pop=1000.
//  5 almost_full[2]=1 mid-stream -> pop=0 that same cycle; push=1 for one more cycle only, then 0.
//    Release -> RR resumes from saved rr_ptr.
//  6 Assert reset while push=1 -> push, push_sel, empties = 0 immediately (async).
//    After 256 grants on ch1 -> grant_cnt_ov=1.

Source files
------------

// File: rtl/arbitro_pkg.sv
// ============================================================================
//  Module      : arbitro_pkg
//  Description : Shared constants for the round-robin / fixed-priority arbiter
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arbitro_pkg;

    localparam int             MODE_FIXED  = 0;
    localparam int             MODE_RR     = 1;
    localparam int             DEF_NUM_CH  = 4;
    localparam int             DEF_CH_W    = 2;
    localparam int             DEF_STATE_W = 4;
    localparam logic [3:0]     INIT_STATE  = 4'b0001;
    localparam int             CNT_W       = 8;

endpackage

`default_nettype wire

// File: rtl/arbitro_rr_prio_pick.sv
// ============================================================================
//  Module      : prio_pick
//  Description : Rotating priority picker: lowest request at or after start
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prio_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         valid
);

    localparam logic [W:0] C_N = N[W:0];

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [W-1:0]   w_pos;
    logic [W:0]     w_sum;

    always_comb begin
        w_dbl = {req, req} >> start;
        w_rot = w_dbl[N-1:0];
        w_pos = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid && w_rot[i]) begin
                valid = 1'b1;
                w_pos = i[W-1:0];
            end
        end
        // Un-rotate: position in rotated vector is an offset from start
        w_sum = {1'b0, w_pos} + {1'b0, start};
        if (w_sum >= C_N)
            w_sum = w_sum - C_N;
        idx = w_sum[W-1:0];
        gnt = '0;
        if (valid)
            gnt[idx] = 1'b1;
    end

endmodule

`default_nettype wire

// File: rtl/arbitro_rr.sv
// ============================================================================
//  Module      : arbitro_rr
//  Description : Input-FIFO pop arbiter with 1-cycle registered push/select
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbitro_rr #(
    parameter int                 NUM_CH     = arbitro_pkg::DEF_NUM_CH,
    parameter int                 CH_W       = arbitro_pkg::DEF_CH_W,
    parameter int                 STATE_W    = arbitro_pkg::DEF_STATE_W,
    parameter logic [STATE_W-1:0] INIT_STATE = arbitro_pkg::INIT_STATE,
    parameter int                 RR_MODE    = arbitro_pkg::MODE_RR
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [STATE_W-1:0]    state,
    input  logic [NUM_CH-1:0]     empty_in,
    input  logic [NUM_CH-1:0]     empty_out,
    input  logic [NUM_CH-1:0]     almost_full,
    output logic [NUM_CH-1:0]     pop,
    output logic                  push,
    output logic [CH_W-1:0]       push_sel,
    output logic [2*NUM_CH-1:0]   empties,
    output logic                  grant_cnt_ov
);

    import arbitro_pkg::*;

    localparam logic [CH_W-1:0] C_LAST = CH_W'(NUM_CH - 1);

    logic [CH_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]  r_cnt [NUM_CH];
    logic [CH_W-1:0]   w_start;
    logic [NUM_CH-1:0] w_gnt;
    logic [CH_W-1:0]   w_win;
    logic              w_valid;
    logic              w_block;
    logic              w_grant;
    logic              w_wrap;

    assign w_start = (RR_MODE == MODE_RR) ? r_rr_ptr : '0;

    prio_pick #(
        .N     (NUM_CH),
        .W     (CH_W)
    ) u_pick (
        .req   (~empty_in),
        .start (w_start),
        .gnt   (w_gnt),
        .idx   (w_win),
        .valid (w_valid)
    );

    // A stall or frozen FSM blocks new pops; any in-flight push still retires
    assign w_block = reset | (state == INIT_STATE) | (|almost_full);
    assign pop     = (w_block || !w_valid) ? '0 : w_gnt;
    assign w_grant = |pop;

    always_comb begin
        w_wrap = 1'b0;
        for (int i = 0; i < NUM_CH; i++)
            w_wrap = w_wrap | (pop[i] & (r_cnt[i] == {CNT_W{1'b1}}));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            push         <= 1'b0;
            push_sel     <= '0;
            empties      <= '0;
            r_rr_ptr     <= '0;
            grant_cnt_ov <= 1'b0;
            for (int i = 0; i < NUM_CH; i++)
                r_cnt[i] <= '0;
        end else begin
            push    <= w_grant;
            empties <= (state == INIT_STATE) ? '0 : {empty_out, empty_in};
            if (w_grant) begin
                push_sel <= w_win;
                if (RR_MODE == MODE_RR)
                    r_rr_ptr <= (w_win == C_LAST) ? '0 : w_win + 1'b1;
            end
            for (int i = 0; i < NUM_CH; i++)
                if (pop[i])
                    r_cnt[i] <= r_cnt[i] + 1'b1;
            grant_cnt_ov <= grant_cnt_ov | w_wrap;
        end
    end

endmodule

`default_nettype wire
